// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: steps FETCH/DECODE/EXEC/MEM/WB and drives datapath selects, ALU op and memory handshake.
// Latency: outputs decode combinationally from the registered state (plus mem_ack, opcode, func, zero); state advances once per clk.
// Backpressure: mem_req/iord/mem_we held until mem_ack; a wait longer than TIMEOUT cycles traps (sticky until rst).
//
// Ports: clk, rst (sync, active-high); opcode/func/zero from datapath; mem_ack from memory;
//        mem_req/mem_we/iord to memory; ir_write, pc_write, pc_source, alu_src_a/b, alu_control,
//        reg_write, reg_dst, mem_to_reg to datapath; retire/illegal/state for status and debug.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WR   = 4'd4,
        S_WB_MEM   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    state_t     cur;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic       waiting;
    logic       timed_out;

    // A memory state without ack this cycle counts as one wait cycle.
    assign waiting   = ((cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR)) && !mem_ack;
    // Ack in the same cycle beats the timeout, because waiting already excludes it.
    assign timed_out = waiting && (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));

    always_comb begin
        nxt         = cur;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 4'b0000;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        state       = 4'd0;
        // Reset forces every output low; nxt is ignored by the register under reset.
        if (!rst) begin
            state = cur;
            case (cur)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = S_DECODE;
                    end else if (timed_out) begin
                        nxt = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        6'b000000:                    nxt = S_EXEC_R;
                        6'b100011, 6'b101011:         nxt = S_MEM_ADDR;
                        6'b000100, 6'b000101:         nxt = S_BRANCH;
                        6'b000010:                    nxt = S_JUMP;
                        6'b001000, 6'b001001, 6'b001100, 6'b001101,
                        6'b001110, 6'b001010, 6'b001011, 6'b001111:
                                                      nxt = S_EXEC_I;
                        default:                      nxt = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    nxt       = S_WB_R;
                    case (func)
                        6'b100000, 6'b100001: alu_control = 4'b0000;
                        6'b100010, 6'b100011: alu_control = 4'b0001;
                        6'b100100:            alu_control = 4'b0010;
                        6'b100101:            alu_control = 4'b0011;
                        6'b100110:            alu_control = 4'b0100;
                        6'b100111:            alu_control = 4'b1010;
                        6'b101010:            alu_control = 4'b1000;
                        6'b101011:            alu_control = 4'b1001;
                        6'b000000:            alu_control = 4'b0101;
                        6'b000010:            alu_control = 4'b0110;
                        6'b000011:            alu_control = 4'b0111;
                        6'b000100:            alu_control = 4'b1011;
                        6'b000110:            alu_control = 4'b1100;
                        6'b000111:            alu_control = 4'b1101;
                        default:              nxt = S_TRAP;
                    endcase
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                    nxt       = S_FETCH;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    nxt       = S_WB_I;
                    case (opcode)
                        6'b001100: alu_control = 4'b0010;
                        6'b001101: alu_control = 4'b0011;
                        6'b001110: alu_control = 4'b0100;
                        6'b001010: alu_control = 4'b1000;
                        6'b001011: alu_control = 4'b1001;
                        6'b001111: alu_control = 4'b1110;
                        default:   alu_control = 4'b0000;
                    endcase
                end
                S_WB_I: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    nxt       = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    nxt       = (opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ack)        nxt = S_WB_MEM;
                    else if (timed_out) nxt = S_TRAP;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    nxt        = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ack) begin
                        retire = 1'b1;
                        nxt    = S_FETCH;
                    end else if (timed_out) begin
                        nxt = S_TRAP;
                    end
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = 4'b0001;
                    pc_source   = 2'b01;
                    // opcode[0] distinguishes BNE (000101) from BEQ (000100).
                    pc_write    = opcode[0] ? !zero : zero;
                    retire      = 1'b1;
                    nxt         = S_FETCH;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    retire    = 1'b1;
                    nxt       = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    nxt = S_TRAP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_FETCH;
            wait_cnt <= 8'd0;
        end else begin
            cur <= nxt;
            // Count only consecutive wait cycles; any ack or non-memory state
            // leaves it at zero, so every memory state is entered with a clear count.
            if (waiting) wait_cnt <= wait_cnt + 8'd1;
            else         wait_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl, built with TIMEOUT=4.
// Latency: checks each state cycle-by-cycle, sampled 3 time units after the rising edge.
// Backpressure: memory waits driven by withholding mem_ack.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] func = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a;
    logic [3:0] alu_control;
    logic       reg_write, reg_dst, mem_to_reg, retire, illegal;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .retire(retire), .illegal(illegal), .state(state)
    );

    // All control outputs packed for one-shot comparison.
    logic [18:0] ctl;
    assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_source, alu_src_a, alu_src_b,
                  alu_control, reg_write, reg_dst, mem_to_reg, retire, illegal};

    function automatic logic [18:0] c(input logic req, we, io, irw, pcw, input logic [1:0] pcs,
                                      input logic asa, input logic [1:0] asb, input logic [3:0] alu,
                                      input logic rw, rd, m2r, ret, ill);
        return {req, we, io, irw, pcw, pcs, asa, asb, alu, rw, rd, m2r, ret, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        ncyc++;
    endtask

    // Inputs are already driven; check this cycle's state and controls, then advance.
    task automatic step(input string tag, input int st, input logic [18:0] e);
        #1;
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " ctl"}, 32'(ctl), 32'(e));
        cyc();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        mem_ack = 1'b0;
        repeat (n) step("reset", 0, 19'd0);
        rst = 1'b0;
    endtask

    task automatic fetch(input int waits);
        ncyc = 0;
        mem_ack = 1'b0;
        repeat (waits) step("fetch wait", 0, c(1,0,0,0,0,2'd0,0,2'd1,4'd0,0,0,0,0,0));
        mem_ack = 1'b1;
        step("fetch ack", 0, c(1,0,0,1,1,2'd0,0,2'd1,4'd0,0,0,0,0,0));
        mem_ack = 1'b0;
    endtask

    task automatic decode(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        func   = fn;
        step("decode", 1, c(0,0,0,0,0,2'd0,0,2'd3,4'd0,0,0,0,0,0));
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [3:0] alu);
        fetch(0);
        decode(6'b000000, fn);
        step("exec_r", 6, c(0,0,0,0,0,2'd0,1,2'd0,alu,0,0,0,0,0));
        step("wb_r", 7, c(0,0,0,0,0,2'd0,0,2'd0,4'd0,1,1,0,1,0));
        check("rtype cycles", 32'(ncyc), 32'd4);
    endtask

    task automatic itype(input logic [5:0] op, input logic [3:0] alu);
        fetch(0);
        decode(op, 6'd0);
        step("exec_i", 8, c(0,0,0,0,0,2'd0,1,2'd2,alu,0,0,0,0,0));
        step("wb_i", 9, c(0,0,0,0,0,2'd0,0,2'd0,4'd0,1,0,0,1,0));
        check("itype cycles", 32'(ncyc), 32'd4);
    endtask

    task automatic branch(input logic [5:0] op, input logic z, input logic pcw);
        fetch(0);
        decode(op, 6'd0);
        zero = z;
        step("branch", 10, c(0,0,0,0,pcw,2'd1,1,2'd0,4'b0001,0,0,0,1,0));
        zero = 1'b0;
        check("branch cycles", 32'(ncyc), 32'd3);
    endtask

    task automatic trap_hold(input int n);
        mem_ack = 1'b1;
        repeat (n) step("trap", 15, 19'd1);
        mem_ack = 1'b0;
    endtask

    initial begin
        // Reset held three cycles: everything low.
        do_reset(3);

        // First fetch straight after reset with ack already high.
        rtype(6'b100000, 4'b0000);
        rtype(6'b100010, 4'b0001);
        rtype(6'b100111, 4'b1010);
        rtype(6'b000011, 4'b0111);
        rtype(6'b101011, 4'b1001);

        itype(6'b001101, 4'b0011);
        itype(6'b001111, 4'b1110);
        itype(6'b001001, 4'b0000);

        // LW with three wait cycles in MEM_RD: 8 cycles in total.
        fetch(0);
        decode(6'b100011, 6'd0);
        step("mem_addr", 2, c(0,0,0,0,0,2'd0,1,2'd2,4'd0,0,0,0,0,0));
        repeat (3) step("mem_rd wait", 3, c(1,0,1,0,0,2'd0,0,2'd0,4'd0,0,0,0,0,0));
        mem_ack = 1'b1;
        step("mem_rd ack", 3, c(1,0,1,0,0,2'd0,0,2'd0,4'd0,0,0,0,0,0));
        mem_ack = 1'b0;
        step("wb_mem", 5, c(0,0,0,0,0,2'd0,0,2'd0,4'd0,1,0,1,1,0));
        check("lw cycles", 32'(ncyc), 32'd8);

        // SW zero-wait: 4 cycles, retires in the ack cycle.
        fetch(0);
        decode(6'b101011, 6'd0);
        step("mem_addr sw", 2, c(0,0,0,0,0,2'd0,1,2'd2,4'd0,0,0,0,0,0));
        mem_ack = 1'b1;
        step("mem_wr ack", 4, c(1,1,1,0,0,2'd0,0,2'd0,4'd0,0,0,0,1,0));
        mem_ack = 1'b0;
        check("sw cycles", 32'(ncyc), 32'd4);

        branch(6'b000100, 1'b1, 1'b1);
        branch(6'b000101, 1'b1, 1'b0);
        branch(6'b000101, 1'b0, 1'b1);

        // Jump.
        fetch(0);
        decode(6'b000010, 6'd0);
        step("jump", 11, c(0,0,0,0,1,2'd2,0,2'd0,4'd0,0,0,0,1,0));
        check("jump cycles", 32'(ncyc), 32'd3);

        // Illegal opcode: sticky trap, ack ignored, cleared by reset.
        fetch(0);
        decode(6'b111111, 6'd0);
        trap_hold(10);
        do_reset(1);

        // Illegal R-type func.
        fetch(0);
        decode(6'b000000, 6'b111111);
        step("exec_r bad", 6, c(0,0,0,0,0,2'd0,1,2'd0,4'd0,0,0,0,0,0));
        trap_hold(10);
        do_reset(1);

        // Timeout: four wait cycles without ack -> trap.
        ncyc = 0;
        repeat (4) step("fetch to", 0, c(1,0,0,0,0,2'd0,0,2'd1,4'd0,0,0,0,0,0));
        trap_hold(2);
        do_reset(1);

        // Ack on the fourth wait cycle wins over the timeout.
        fetch(3);
        decode(6'b000010, 6'd0);
        step("jump after late ack", 11, c(0,0,0,0,1,2'd2,0,2'd0,4'd0,0,0,0,1,0));

        // Reset mid-wait drops mem_req at once and ignores a concurrent ack.
        mem_ack = 1'b0;
        step("fetch pre-rst", 0, c(1,0,0,0,0,2'd0,0,2'd1,4'd0,0,0,0,0,0));
        rst = 1'b1;
        mem_ack = 1'b1;
        step("rst mid-wait", 0, 19'd0);
        rst = 1'b0;
        mem_ack = 1'b0;
        step("fetch post-rst", 0, c(1,0,0,0,0,2'd0,0,2'd1,4'd0,0,0,0,0,0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencing controller for the CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects, register and PC write enables, and the 4-bit ALU operation code. It also owns the request/acknowledge handshake to the single shared instruction/data memory. Unsupported encodings and memory timeouts move it to a sticky trap state.

## Interface
- `TIMEOUT`, default 255: maximum cycles to wait for `mem_ack` in any memory state before trapping. Range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction register bits [31:26], valid from DECODE onward.
- `func` in 6: instruction register bits [5:0].
- `zero` in 1: ALU zero flag.
- `mem_ack` in 1: memory completed the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: request is a write.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC.
- `pc_source` out 2: PC source select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B select. 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_control` out 4: ALU operation code.
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 each: register file write enable and writeback selects.
- `retire` out 1: one-cycle pulse in the final state of each instruction.
- `illegal` out 1: sticky trap flag.
- `state` out 4: current state, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WR=4, WB_MEM=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11, TRAP=15.
- Any output not listed for a state is 0.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_control`=ADD.
  - When `mem_ack`=1: `ir_write`=1, `pc_write`=1, `pc_source`=00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, ADD (computes the branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC_R.
  - 100011, 101011 → MEM_ADDR.
  - 000100, 000101 → BRANCH.
  - 000010 → JUMP.
  - 001000, 001001, 001100, 001101, 001110, 001010, 001011, 001111 → EXEC_I.
  - Any other opcode → TRAP.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_control` decoded from `func`:
  - 100000/100001 → 0000; 100010/100011 → 0001; 100100 → 0010; 100101 → 0011; 100110 → 0100; 100111 → 1010.
  - 101010 → 1000; 101011 → 1001.
  - 000000 → 0101; 000010 → 0110; 000011 → 0111.
  - 000100 → 1011; 000110 → 1100; 000111 → 1101.
  - Any other `func` → TRAP. Otherwise next state WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `retire`=1, next state FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10. `alu_control`: ADDI/ADDIU → 0000, ANDI → 0010, ORI → 0011, XORI → 0100, SLTI → 1000, SLTIU → 1001, LUI → 1110. Next state WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0, `retire`=1, next state FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, ADD. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_req`=1, `iord`=1. Next state WB_MEM on `mem_ack`.
- WB_MEM: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `retire`=1, next state FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ack`: `retire`=1, next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_control`=0001, `pc_source`=01.
  - `pc_write` = `zero` for BEQ, `!zero` for BNE.
  - `retire`=1, next state FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `retire`=1, next state FETCH.
- TRAP: all control outputs 0, `illegal`=1. Only `rst` exits TRAP.
- Timeout counter: 8 bits, cleared on entry to FETCH, MEM_RD or MEM_WR, incremented each cycle spent waiting without `mem_ack`. Reaching `TIMEOUT` → TRAP. `mem_ack` arriving on the same cycle the counter reaches `TIMEOUT` wins: the transfer completes normally.

## Timing
- Reset:
  - While `rst`=1, every output is forced to 0.
  - At the next clock edge `state` becomes FETCH, `illegal` and the timeout counter clear.
  - The first `mem_req` appears in the first cycle after `rst` falls.
  - `rst` asserted mid-wait drops `mem_req` in the same cycle; an ack arriving during reset is ignored.
- `mem_ack` is sampled only in FETCH, MEM_RD and MEM_WR. In any other state it is ignored.
- `mem_req`, `iord` and `mem_we` are held stable until the ack cycle.
- `ir_write`, `pc_write` and `retire` are single-cycle pulses.
- Cycle counts with zero-wait memory (ack in the request cycle):
  - R-type 4, I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3.
  - Each wait cycle adds 1.
- `alu_control` is combinational from state, `opcode` and `func`. `pc_write` in BRANCH is combinational on `zero`.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0. Release `rst`, `mem_ack`=1 → `state`=0, `mem_req`=1 in the next cycle, then DECODE.
- ADD (`opcode`=0, `func`=100000), zero-wait → states 0,1,6,7. `alu_control`=0000 in EXEC_R; `reg_write`=1, `reg_dst`=1 and `retire`=1 in WB_R; 4 cycles total.
- LW with `mem_ack` delayed 3 cycles in MEM_RD → `mem_req`=1 and `iord`=1 held 4 cycles, then WB_MEM with `mem_to_reg`=1. Total 8 cycles.
- BEQ with `zero`=1 → `pc_write`=1, `pc_source`=01. BNE with `zero`=1 → `pc_write`=0. Both retire in 3 cycles.
- Illegal opcode 111111, and R-type `func`=111111 → TRAP, `illegal`=1 held 10 cycles with `mem_req`=0, cleared by `rst`.
- `TIMEOUT`=4, no `mem_ack` in FETCH → TRAP after 4 wait cycles. Ack on the 4th wait cycle → DECODE, no trap.
